// File: rtl/exibir_matriz_rega_mux_if.sv
// ============================================================================
// Module : exibir_matriz_rega_mux_if
// Brief  : Zone flag inputs and multiplexed 7-segment outputs of the scanner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface exibir_matriz_rega_mux_if #(
  parameter int N_ZONAS = 4
);
  localparam int ZW = (N_ZONAS > 1) ? $clog2(N_ZONAS) : 1;

  logic                en;
  logic [N_ZONAS-1:0]  AS;
  logic [N_ZONAS-1:0]  US;
  logic [N_ZONAS-1:0]  GT;
  logic [6:0]          seg;
  logic [N_ZONAS-1:0]  dig;
  logic [ZW-1:0]       zona;
  logic                erro;

  modport master (
    output en, AS, US, GT,
    input  seg, dig, zona, erro
  );

  modport slave (
    input  en, AS, US, GT,
    output seg, dig, zona, erro
  );
endinterface

`default_nettype wire

// File: rtl/exibir_matriz_rega_mux.sv
// ============================================================================
// Module : exibir_matriz_rega_mux
// Brief  : Scans irrigation zones onto a multiplexed 7-segment display,
//          blinking zones whose flag combination is invalid.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exibir_matriz_rega_mux #(
  parameter int N_ZONAS   = 4,
  parameter int DWELL     = 50000,
  parameter int BLINK_DIV = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  exibir_matriz_rega_mux_if.slave bus
);

  localparam int ZW = (N_ZONAS > 1)   ? $clog2(N_ZONAS)   : 1;
  localparam int DW = (DWELL > 2)     ? $clog2(DWELL)     : 1;
  localparam int SW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [ZW-1:0] c_last_zone  = ZW'(N_ZONAS - 1);
  localparam logic [DW-1:0] c_last_dwell = DW'(DWELL - 2);
  localparam logic [SW-1:0] c_last_scan  = SW'(BLINK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  logic [1:0]    r_state;
  logic [ZW-1:0] r_zone;
  logic [DW-1:0] r_dwell;
  logic [SW-1:0] r_scan;
  logic          r_blink;
  logic [2:0]    r_snap;    // {AS, US, GT} of the zone being shown

  logic [6:0]         r_seg;
  logic [N_ZONAS-1:0] r_dig;
  logic [ZW-1:0]      r_zona;
  logic               r_erro;

  logic [6:0]         w_glyph;
  logic               w_snap_bad;
  logic [N_ZONAS-1:0] w_dig_sel;

  function automatic logic [6:0] glyph(input logic as_b, input logic us_b,
                                       input logic gt_b);
    glyph = {1'b1, ~us_b & ~as_b & gt_b, 1'b1, ~us_b & as_b & ~gt_b,
             1'b1, 1'b1, ~as_b | gt_b | us_b};
  endfunction

  always_comb begin
    w_glyph    = glyph(r_snap[2], r_snap[1], r_snap[0]);
    w_snap_bad = ~r_snap[1] & r_snap[2] & r_snap[0];
    w_dig_sel  = '0;
    w_dig_sel[r_zone] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_zone  <= '0;
      r_dwell <= '0;
      r_scan  <= '0;
      r_blink <= 1'b0;
      r_snap  <= '0;
    end else if (!bus.en) begin
      // scan counter and blink phase are deliberately held across IDLE
      r_state <= S_IDLE;
      r_zone  <= '0;
      r_dwell <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_BLANK;
          r_zone  <= '0;
          r_dwell <= '0;
        end
        S_BLANK: begin
          r_state <= S_SHOW;
          r_dwell <= '0;
          r_snap  <= {bus.AS[r_zone], bus.US[r_zone], bus.GT[r_zone]};
        end
        S_SHOW: begin
          if (r_dwell == c_last_dwell) begin
            r_state <= S_BLANK;
            r_dwell <= '0;
            if (r_zone == c_last_zone) begin
              r_zone <= '0;
              if (r_scan == c_last_scan) begin
                r_scan  <= '0;
                r_blink <= ~r_blink;
              end else begin
                r_scan <= r_scan + 1'b1;
              end
            end else begin
              r_zone <= r_zone + 1'b1;
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs clear on the same edge that samples en low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg  <= '0;
      r_dig  <= '0;
      r_zona <= '0;
      r_erro <= 1'b0;
    end else begin
      r_erro <= |(~bus.US & bus.AS & bus.GT);
      if (bus.en && r_state == S_SHOW) begin
        r_dig  <= w_dig_sel;
        r_seg  <= (r_blink && w_snap_bad) ? 7'd0 : w_glyph;
        r_zona <= r_zone;
      end else begin
        r_dig  <= '0;
        r_seg  <= '0;
        r_zona <= bus.en ? r_zone : '0;
      end
    end
  end

  assign bus.seg  = r_seg;
  assign bus.dig  = r_dig;
  assign bus.zona = r_zona;
  assign bus.erro = r_erro;

endmodule

`default_nettype wire
